// File: rtl/sram_ctrl.sv
// 32-bit word bus slave backed by a 16-bit asynchronous SRAM; each word is two halfword phases, low half first.
// Optional one-word read buffer enabled by defining SRAM_CTRL_RDBUF_EN.
module sram_ctrl #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_stb,
    input  logic        bus_we,
    input  logic [23:2] bus_addr,
    input  logic [31:0] bus_din,
    output logic [31:0] bus_dout,
    output logic        bus_ack,
    output logic [19:0] sram_addr,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in
);

    typedef enum logic [2:0] {
        IDLE, RD_LO, RD_HI, WR_LO, WR_LO_H, WR_HI, WR_HI_H, DONE
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last;
    logic [18:0] waddr_q;
    logic [31:0] wdata_q;
    logic [18:0] word_sel;
    logic [31:0] wdat_sel;
    logic        rd_hit;

    logic [31:0] dout_q, dout_d;
    logic        ack_q, ack_d;
    logic [19:0] addr_q, addr_d;
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic [15:0] dq_out_q, dq_out_d;
    logic        dq_oe_q, dq_oe_d;

    logic        unused_hi;
    assign unused_hi = ^bus_addr[23:21];

    assign last = (cnt_q == WAIT_LAST);

    // In IDLE the request has not been latched yet, so take it straight from the bus.
    assign word_sel = (state_q == IDLE) ? bus_addr[20:2] : waddr_q;
    assign wdat_sel = (state_q == IDLE) ? bus_din : wdata_q;

`ifdef SRAM_CTRL_RDBUF_EN
    logic        rb_vld_q;
    logic [18:0] rb_tag_q;
    logic [31:0] rb_data_q;
    logic        rb_fill;
    logic        rb_wupd;

    assign rd_hit  = rb_vld_q && (rb_tag_q == bus_addr[20:2]);
    assign rb_fill = (state_q == RD_HI) && last;
    assign rb_wupd = (state_q == WR_HI_H) && rb_vld_q && (rb_tag_q == waddr_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rb_vld_q <= 1'b0;
        end else if (rb_fill) begin
            rb_vld_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rb_fill) begin
            rb_tag_q  <= waddr_q;
            rb_data_q <= {sram_dq_in, dout_q[15:0]};
        end else if (rb_wupd) begin
            rb_data_q <= wdata_q;
        end
    end
`else
    assign rd_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus_stb) begin
                    if (bus_we)      state_d = WR_LO;
                    else if (rd_hit) state_d = DONE;
                    else             state_d = RD_LO;
                end
            end
            RD_LO:   if (last) state_d = RD_HI;
            RD_HI:   if (last) state_d = DONE;
            WR_LO:   if (last) state_d = WR_LO_H;
            WR_LO_H: state_d = WR_HI;
            WR_HI:   if (last) state_d = WR_HI_H;
            WR_HI_H: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        cnt_d = 4'd0;
        if ((state_d == state_q) && (state_q inside {RD_LO, RD_HI, WR_LO, WR_HI})) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // SRAM pins are registered, so they are decoded from the state being entered.
    always_comb begin
        ce_n_d   = 1'b1;
        oe_n_d   = 1'b1;
        we_n_d   = 1'b1;
        dq_oe_d  = 1'b0;
        addr_d   = addr_q;
        dq_out_d = dq_out_q;
        case (state_d)
            RD_LO: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                addr_d = {word_sel, 1'b0};
            end
            RD_HI: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                addr_d = {word_sel, 1'b1};
            end
            WR_LO, WR_LO_H: begin
                ce_n_d   = 1'b0;
                we_n_d   = (state_d != WR_LO);
                dq_oe_d  = 1'b1;
                addr_d   = {word_sel, 1'b0};
                dq_out_d = wdat_sel[15:0];
            end
            WR_HI, WR_HI_H: begin
                ce_n_d   = 1'b0;
                we_n_d   = (state_d != WR_HI);
                dq_oe_d  = 1'b1;
                addr_d   = {word_sel, 1'b1};
                dq_out_d = wdat_sel[31:16];
            end
            default: ;
        endcase

        ack_d  = (state_d == DONE);
        dout_d = dout_q;
        if ((state_q == RD_LO) && last) dout_d[15:0]  = sram_dq_in;
        if ((state_q == RD_HI) && last) dout_d[31:16] = sram_dq_in;
`ifdef SRAM_CTRL_RDBUF_EN
        if ((state_q == IDLE) && (state_d == DONE)) dout_d = rb_data_q;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            dout_q   <= 32'd0;
            ack_q    <= 1'b0;
            addr_q   <= 20'd0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            dq_out_q <= 16'd0;
            dq_oe_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            ack_q    <= ack_d;
            addr_q   <= addr_d;
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
            dq_out_q <= dq_out_d;
            dq_oe_q  <= dq_oe_d;
        end
    end

    always_ff @(posedge clk) begin
        if ((state_q == IDLE) && bus_stb) begin
            waddr_q <= bus_addr[20:2];
            wdata_q <= bus_din;
        end
    end

    assign bus_dout    = dout_q;
    assign bus_ack     = ack_q;
    assign sram_addr   = addr_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_ub_n   = ce_n_q;
    assign sram_lb_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: word-level reference memory, halfword SRAM model, decoupled ack monitor.
module tb_sram_ctrl;

    localparam int WAIT = 1;
    localparam int P    = WAIT + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_stb, bus_we;
    logic [23:2] bus_addr;
    logic [31:0] bus_din, bus_dout;
    logic        bus_ack;
    logic [19:0] sram_addr;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe;

    sram_ctrl #(.WAIT_CYCLES(WAIT)) dut (
        .clk(clk), .rst(rst),
        .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_din(bus_din), .bus_dout(bus_dout), .bus_ack(bus_ack),
        .sram_addr(sram_addr), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n),
        .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          rd;
        bit          hit;
        logic [18:0] w;
        logic [31:0] data;
        int          k;
    } exp_t;

    exp_t        sb[$];
    int          issued   = 0;
    int          resolved = 0;
    int          last_ack = -100;
    int          cmp_cnt  = 0;
    int          err_cnt  = 0;
    logic [31:0] ref_mem [0:511];
    logic [15:0] mem [0:1023];
`ifdef SRAM_CTRL_RDBUF_EN
    bit          rb_vld = 0;
    logic [18:0] rb_tag = '0;
`endif

    function automatic logic [15:0] init_half(input int i);
        if (i == 32) return 16'h1234;
        if (i == 33) return 16'hABCD;
        return 16'(i * 40503) ^ 16'h5A3C;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
        forever @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl_n"}, 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'h1f);
        check({tag, "_dq_oe"}, 32'(sram_dq_oe), 32'd0);
        check({tag, "_addr"}, 32'(sram_addr), 32'd0);
        check({tag, "_dq_out"}, 32'(sram_dq_out), 32'd0);
        check({tag, "_ack"}, 32'(bus_ack), 32'd0);
        check({tag, "_dout"}, bus_dout, 32'd0);
    endtask

    // Asynchronous SRAM: reads are combinational, a write lands while ce_n and we_n are both low.
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[9:0]] : 16'h5A5A;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = init_half(i);
        forever begin
            @(negedge clk);
            if (rst && !sram_ce_n && !sram_we_n) mem[sram_addr[9:0]] = sram_dq_out;
        end
    end

    // Monitor: per-transfer pin activity plus ack-time comparison against the scoreboard.
    initial begin
        int          ce_cnt = 0;
        int          we_cnt = 0;
        logic [19:0] first_addr = '0;
        logic [19:0] last_addr = '0;
        exp_t        e;
        int          exp_lat, exp_ce, exp_we;
        forever begin
            @(negedge clk);
            if (!rst) begin
                resolved += sb.size();
                sb.delete();
                ce_cnt   = 0;
                we_cnt   = 0;
                last_ack = -100;
            end else begin
                if (!sram_ce_n) begin
                    ce_cnt++;
                    if (ce_cnt == 1) first_addr = sram_addr;
                    last_addr = sram_addr;
                    if (!sram_we_n) we_cnt++;
                    check("byte_lanes", 32'({sram_ub_n, sram_lb_n}), 32'd0);
                    check("dq_oe_vs_oe_n", 32'(sram_dq_oe), 32'(sram_oe_n));
                end else begin
                    check("idle_ctrl", 32'({sram_we_n, sram_oe_n, sram_dq_oe}), 32'b110);
                end
                if (bus_ack) begin
                    if (sb.size() == 0) begin
                        cmp_cnt++;
                        err_cnt++;
                        $display("FAIL spurious_ack: ack with no transfer outstanding (cycle %0d)", cyc);
                    end else begin
                        e = sb.pop_front();
                        exp_lat = e.rd ? (e.hit ? 1 : 2 * P + 1) : 2 * P + 3;
                        exp_ce  = e.rd ? (e.hit ? 0 : 2 * P) : 2 * P + 2;
                        exp_we  = e.rd ? 0 : 2 * P;
                        check("ack_latency", 32'(cyc + 1 - e.k), 32'(exp_lat));
                        check("ce_cycles", 32'(ce_cnt), 32'(exp_ce));
                        check("we_cycles", 32'(we_cnt), 32'(exp_we));
                        if (exp_ce > 0) begin
                            check("addr_lo", 32'(first_addr), 32'({e.w, 1'b0}));
                            check("addr_hi", 32'(last_addr), 32'({e.w, 1'b1}));
                        end
                        if (e.rd) check("rd_data", bus_dout, e.data);
                        resolved++;
                    end
                    last_ack = cyc;
                    ce_cnt   = 0;
                    we_cnt   = 0;
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (resolved != issued && n < 60);
        if (resolved != issued) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL ack_timeout: %0d acks outstanding, expected 0", issued - resolved);
            finish_run();
        end
    endtask

    task automatic issue(input bit rd, input logic [23:2] a, input logic [31:0] d,
                         input int gap, input bit drop, output int k);
        exp_t        e;
        logic [18:0] w;
        int          c, n;
        w = a[20:2];
        wait_idle();
        if (gap > 0) begin
            bus_stb = 1'b0;
            repeat (gap) begin
                @(negedge clk);
                #1;
            end
        end
        c = cyc;
        k = (c + 1 > last_ack + 2) ? c + 1 : last_ack + 2;
        e.rd  = rd;
        e.hit = 1'b0;
        e.w   = w;
        e.k   = k;
        if (rd) begin
            e.data = ref_mem[w[8:0]];
`ifdef SRAM_CTRL_RDBUF_EN
            e.hit  = rb_vld && (rb_tag == w);
            rb_vld = 1'b1;
            rb_tag = w;
`endif
        end else begin
            e.data = d;
            ref_mem[w[8:0]] = d;
        end
        sb.push_back(e);
        issued++;
        bus_stb  = 1'b1;
        bus_we   = !rd;
        bus_addr = a;
        bus_din  = d;
        if (drop) begin
            n = 0;
            while (cyc < k && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
            bus_stb = 1'b0;
        end
    endtask

    initial begin
        int          k, n;
        bit          rd, drop;
        logic [23:2] a;
        rst      = 1'b1;
        bus_stb  = 1'b0;
        bus_we   = 1'b0;
        bus_addr = '0;
        bus_din  = '0;
        for (int w = 0; w < 512; w++) ref_mem[w] = {init_half(2 * w + 1), init_half(2 * w)};

        #2 rst = 1'b0;
        #1 check_reset_outputs("rst");
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;

        issue(1'b1, 22'h000010, 32'h0, 1, 1'b0, k);
        issue(1'b0, 22'h000011, 32'hDEADBEEF, 0, 1'b0, k);
        issue(1'b1, 22'h200011, 32'h0, 0, 1'b0, k);
        issue(1'b1, 22'h000010, 32'h0, 1, 1'b0, k);
        issue(1'b1, 22'h000010, 32'h0, 0, 1'b0, k);
        issue(1'b0, 22'h000010, 32'h55AA55AA, 0, 1'b0, k);
        issue(1'b1, 22'h000010, 32'h0, 0, 1'b0, k);

        // Reset in the middle of the high-half read phase.
        issue(1'b1, 22'h000100, 32'h0, 1, 1'b0, k);
        n = 0;
        while (cyc < k + P && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("pre_abort_ce_n", 32'(sram_ce_n), 32'd0);
        check("pre_abort_addr", 32'(sram_addr), 32'h00201);
        bus_stb = 1'b0;
        rst     = 1'b0;
        #1 check_reset_outputs("abort");
`ifdef SRAM_CTRL_RDBUF_EN
        rb_vld = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        issue(1'b1, 22'h000100, 32'h0, 1, 1'b0, k);

        for (int i = 0; i < 150; i++) begin
            rd   = 1'($urandom_range(0, 1));
            a    = {3'($urandom), 14'd0, 5'($urandom)};
            drop = ($urandom_range(0, 4) == 0);
            issue(rd, a, $urandom, $urandom_range(0, 2), drop, k);
        end

        wait_idle();
        bus_stb = 1'b0;
        repeat (4) @(negedge clk);
        #1 check("scoreboard_empty", 32'(sb.size()), 32'd0);
        finish_run();
    end

endmodule
